puf_ro_scheduler: RTL and testbench

PUF_RO_SCHEDULER -- requirements
Module: puf_ro_scheduler

---
 rtl/puf_pkg.sv | 17 +
 rtl/puf_ro_scheduler_if.sv | 26 ++
 rtl/puf_rr_arb.sv | 37 +++
 rtl/puf_ro_scheduler.sv | 165 ++++++++++++++++
 tb/tb_puf_ro_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - shared types and constants for the PUF ring-oscillator scheduler
package puf_pkg;

  localparam int NRO_DEF = 9;
  localparam int CW_DEF  = 25;
  localparam int CHAL_W  = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_CAPTURE,
    S_COMPARE,
    S_RESPOND
  } state_t;

endpackage

// File: rtl/puf_ro_scheduler_if.sv
// rtl/puf_ro_scheduler_if.sv - challenge request / PUF response handshake bundle
interface puf_ro_scheduler_if #(
  parameter int NRO = puf_pkg::NRO_DEF
);
  import puf_pkg::*;

  logic [1:0]          req_valid;
  logic [2*CHAL_W-1:0] req_chal;
  logic [1:0]          req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [NRO-2:0]      rsp_data;
  logic                rsp_id;
  logic [CHAL_W-1:0]   rsp_chal;

  modport master (
    output req_valid, req_chal, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_chal
  );

  modport slave (
    input  req_valid, req_chal, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_chal
  );

endinterface

// File: rtl/puf_rr_arb.sv
// rtl/puf_rr_arb.sv - two-way round-robin arbiter with one-hot grant
module puf_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic prio_q, prio_d;

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!prio_q || !req[1])) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

  // Priority goes to whichever requester was not just served.
  always_comb begin
    prio_d = prio_q;
    if (advance && (gnt != 2'b00)) begin
      prio_d = gnt[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/puf_ro_scheduler.sv
// rtl/puf_ro_scheduler.sv - sequences ROs per challenge, counts edges, emits pairwise-compare response
module puf_ro_scheduler
  import puf_pkg::*;
#(
  parameter int NRO        = NRO_DEF,
  parameter int CW         = CW_DEF,
  parameter int WINDOW     = 1000,
  parameter int SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  puf_ro_scheduler_if.slave bus,
  input  logic              abort,
  output logic              ro_en,
  output logic [CHAL_W-1:0] ro_chal,
  output logic [3:0]        ro_sel,
  output logic              ro_clr,
  input  logic [CW-1:0]     ro_cnt,
  output logic              busy
);

  localparam int TW = $clog2((WINDOW > SETTLE_CYC ? WINDOW : SETTLE_CYC) + 1);

  state_t            state_q, state_d;
  logic [3:0]        sel_q, sel_d;
  logic [TW-1:0]     cyc_q, cyc_d;
  logic [CHAL_W-1:0] chal_q, chal_d;
  logic              id_q, id_d;
  logic [NRO-2:0]    rdata_q, rdata_d;
  logic              rid_q, rid_d;
  logic [CHAL_W-1:0] rchal_q, rchal_d;
  logic [CW-1:0]     cnt_q [NRO];
  logic [NRO-2:0]    cmp;
  logic [1:0]        gnt;
  logic              idle, grant;

  assign idle  = (state_q == S_IDLE);
  assign grant = idle && !rst && (gnt != 2'b00);

  puf_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid & {2{idle}}),
    .advance (grant),
    .gnt     (gnt)
  );

  always_comb begin
    cmp = '0;
    for (int k = 0; k < NRO - 1; k++) begin
      cmp[k] = cnt_q[k] > cnt_q[k+1];
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cyc_d   = cyc_q;
    chal_d  = chal_q;
    id_d    = id_q;
    rdata_d = rdata_q;
    rid_d   = rid_q;
    rchal_d = rchal_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          chal_d  = gnt[1] ? bus.req_chal[2*CHAL_W-1:CHAL_W] : bus.req_chal[CHAL_W-1:0];
          id_d    = gnt[1];
          sel_d   = '0;
          cyc_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cyc_q == TW'(SETTLE_CYC - 1)) begin
          cyc_d   = '0;
          state_d = S_MEASURE;
        end else begin
          cyc_d = cyc_q + TW'(1);
        end
      end
      S_MEASURE: begin
        if (cyc_q == TW'(WINDOW - 1)) begin
          cyc_d   = '0;
          state_d = S_CAPTURE;
        end else begin
          cyc_d = cyc_q + TW'(1);
        end
      end
      S_CAPTURE: begin
        if (sel_q == 4'(NRO - 1)) begin
          state_d = S_COMPARE;
        end else begin
          sel_d   = sel_q + 4'd1;
          state_d = S_SETTLE;
        end
      end
      S_COMPARE: begin
        rdata_d = cmp;
        rid_d   = id_q;
        rchal_d = chal_q;
        state_d = S_RESPOND;
      end
      S_RESPOND: begin
        if (bus.rsp_ready) begin
          sel_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort drops the measurement; an already-published response is never withdrawn.
    if (abort && !(state_q inside {S_IDLE, S_RESPOND})) begin
      state_d = S_IDLE;
      sel_d   = '0;
      rdata_d = rdata_q;
      rid_d   = rid_q;
      rchal_d = rchal_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cyc_q   <= '0;
      chal_q  <= '0;
      id_q    <= 1'b0;
      rdata_q <= '0;
      rid_q   <= 1'b0;
      rchal_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cyc_q   <= cyc_d;
      chal_q  <= chal_d;
      id_q    <= id_d;
      rdata_q <= rdata_d;
      rid_q   <= rid_d;
      rchal_q <= rchal_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NRO; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (state_q == S_CAPTURE) begin
      cnt_q[sel_q] <= ro_cnt;
    end
  end

  assign ro_en         = state_q inside {S_SETTLE, S_MEASURE, S_CAPTURE, S_COMPARE};
  assign ro_clr        = !(state_q inside {S_MEASURE, S_CAPTURE});
  assign ro_sel        = sel_q;
  assign ro_chal       = chal_q;
  assign busy          = !idle;
  assign bus.req_ready = grant ? gnt : 2'b00;
  assign bus.rsp_valid = (state_q == S_RESPOND);
  assign bus.rsp_data  = rdata_q;
  assign bus.rsp_id    = rid_q;
  assign bus.rsp_chal  = rchal_q;

endmodule

// File: tb/tb_puf_ro_scheduler.sv
// tb/tb_puf_ro_scheduler.sv - directed bench with a per-cycle timeline model of the scheduler
module tb_puf_ro_scheduler;
  import puf_pkg::*;

  localparam int NRO    = 9;
  localparam int CW     = 25;
  localparam int WINDOW = 8;
  localparam int SETTLE = 4;
  localparam int PER    = SETTLE + WINDOW + 1;
  localparam int LAT    = NRO * PER + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          abort = 1'b0;
  logic          ro_en, ro_clr, busy;
  logic [5:0]    ro_chal;
  logic [3:0]    ro_sel;
  logic [CW-1:0] ro_cnt;
  logic [CW-1:0] pat [16];
  int            checks = 0;
  int            errors = 0;
  int            cyc_n = 0;

  puf_ro_scheduler_if #(.NRO(NRO)) bus ();

  puf_ro_scheduler #(
    .NRO(NRO), .CW(CW), .WINDOW(WINDOW), .SETTLE_CYC(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .abort(abort), .ro_en(ro_en), .ro_chal(ro_chal),
    .ro_sel(ro_sel), .ro_clr(ro_clr), .ro_cnt(ro_cnt), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  assign ro_cnt = pat[ro_sel];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Model: t counts cycles since the grant; outputs follow from the settle/window/capture timeline.
  bit         m_ok = 0, m_act = 0, m_prio = 0, m_id = 0, m_rid = 0;
  int         m_t = 0, m_g = 0, m_off = 0;
  logic [5:0] m_chal = '0, m_rchal = '0;
  logic [7:0] m_rdata = '0;
  logic [1:0] m_rr;

  function automatic logic [7:0] expect_data();
    logic [7:0] d;
    for (int k = 0; k < NRO - 1; k++) d[k] = pat[k] > pat[k+1];
    return d;
  endfunction

  function automatic int pick(input logic [1:0] v, input bit prio);
    if (v == 2'b11) return prio ? 1 : 0;
    return v[1] ? 1 : 0;
  endfunction

  initial forever begin
    @(negedge clk);
    if (m_ok) begin
      m_rr = 2'b00;
      if (!rst && !m_act && bus.req_valid != 2'b00)
        m_rr = (pick(bus.req_valid, m_prio) == 1) ? 2'b10 : 2'b01;
      chk("req_ready", 32'(bus.req_ready), 32'(m_rr));
      chk("busy", 32'(busy), 32'(m_act));
      chk("ro_en", 32'(ro_en), 32'(m_act && m_t <= NRO * PER + 1));
      chk("ro_sel", 32'(ro_sel), !m_act ? 0 : (m_t <= NRO * PER ? (m_t - 1) / PER : NRO - 1));
      chk("ro_chal", 32'(ro_chal), 32'(m_chal));
      m_off = (m_t - 1) % PER;
      if (!m_act)
        chk("ro_clr_idle", 32'(ro_clr), 1);
      else if (m_t <= NRO * PER && m_off < SETTLE)
        chk("ro_clr_settle", 32'(ro_clr), 1);
      else if (m_t <= NRO * PER && m_off < SETTLE + WINDOW)
        chk("ro_clr_measure", 32'(ro_clr), 0);
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_act && m_t == LAT));
      chk("rsp_data", 32'(bus.rsp_data), 32'(m_rdata));
      chk("rsp_id", 32'(bus.rsp_id), 32'(m_rid));
      chk("rsp_chal", 32'(bus.rsp_chal), 32'(m_rchal));
    end
    // Inputs only change just after a rising edge, so what is seen now is what the next edge samples.
    if (rst) begin
      m_ok = 1; m_act = 0; m_prio = 0; m_t = 0; m_id = 0;
      m_chal = '0; m_rdata = '0; m_rid = 0; m_rchal = '0;
    end else if (!m_act) begin
      if (bus.req_valid != 2'b00) begin
        m_g    = pick(bus.req_valid, m_prio);
        m_prio = (m_g == 0);
        m_act  = 1;
        m_t    = 1;
        m_id   = (m_g == 1);
        m_chal = bus.req_chal[6*m_g +: 6];
      end
    end else if (m_t < LAT) begin
      if (abort) begin
        m_act = 0;
      end else begin
        m_t++;
        if (m_t == LAT) begin
          m_rdata = expect_data();
          m_rid   = m_id;
          m_rchal = m_chal;
        end
      end
    end else if (bus.rsp_ready) begin
      m_act = 0;
    end
  end

  task automatic goto_cycle(input int c);
    while (cyc_n < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_grant(input logic [1:0] mask, output int who, output int gc);
    who = -1;
    gc  = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((bus.req_ready & mask) != 2'b00) begin
        who = bus.req_ready[1] ? 1 : 0;
        gc  = cyc_n;
        break;
      end
    end
    chk("grant_seen", 32'(who >= 0), 1);
  endtask

  task automatic wait_rsp(output int rc);
    rc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        rc = cyc_n;
        break;
      end
    end
    chk("rsp_seen", 32'(rc >= 0), 1);
  endtask

  task automatic handshake(input bit with_abort);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    abort = with_abort;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    abort = 1'b0;
  endtask

  task automatic run_one(input int id, input logic [5:0] ch, input bit ab,
                         output logic [7:0] d, output int lat);
    int who, g, r;
    bus.req_chal[6*id +: 6] = ch;
    bus.req_valid[id] = 1'b1;
    wait_grant((id == 1) ? 2'b10 : 2'b01, who, g);
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
    bus.req_chal = ~bus.req_chal;
    wait_rsp(r);
    lat = r - g;
    d   = bus.rsp_data;
    chk("run_rsp_id", 32'(bus.rsp_id), 32'(id));
    chk("run_rsp_chal", 32'(bus.rsp_chal), 32'(ch));
    handshake(ab);
  endtask

  initial begin
    int who, g, r, lat, bad;
    int grants [4];
    logic [7:0] d, held;
    bus.req_valid = 2'b00;
    bus.req_chal  = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) pat[i] = CW'(100 - i);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_ro_clr", 32'(ro_clr), 1);
    chk("reset_ro_en", 32'(ro_en), 0);
    chk("reset_rsp_data", 32'(bus.rsp_data), 0);
    @(posedge clk); #1;

    run_one(0, 6'h2A, 1'b0, d, lat);
    chk("descending_data", 32'(d), 32'h0FF);
    chk("latency", 32'(lat), 119);

    for (int i = 0; i < 16; i++) pat[i] = CW'(50);
    run_one(1, 6'h15, 1'b1, d, lat);
    chk("equal_data", 32'(d), 32'h000);

    for (int i = 0; i < 16; i++) pat[i] = (i % 2 == 0) ? CW'(10) : CW'(20);
    run_one(0, 6'h3F, 1'b0, d, lat);
    chk("alternating_data", 32'(d), 32'h0AA);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_chal  = {6'h0B, 6'h0A};
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(2'b11, who, g);
      grants[k] = who;
    end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    wait_rsp(r);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) chk("rr_order", 32'(grants[k]), 32'(k % 2));

    bus.req_chal  = {6'h22, 6'h11};
    bus.req_valid = 2'b01;
    wait_grant(2'b01, who, g);
    @(posedge clk); #1;
    bus.req_valid = 2'b10;
    wait_rsp(r);
    held = bus.rsp_data;
    bad  = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_data != held || bus.req_ready != 2'b00) bad++;
    end
    chk("hold_stable", 32'(bad), 0);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("hold_idle", 32'(busy), 0);
    chk("hold_pending_grant", 32'(bus.req_ready), 32'h2);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    wait_rsp(r);
    chk("pending_rsp_chal", 32'(bus.rsp_chal), 32'h22);
    handshake(1'b0);

    for (int i = 0; i < 16; i++) pat[i] = CW'(100 - i);
    bus.req_chal[5:0] = 6'h33;
    bus.req_valid = 2'b01;
    wait_grant(2'b01, who, g);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    goto_cycle(g + 60);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_pre_sel", 32'(ro_sel), 4);
    chk("abort_pre_clr", 32'(ro_clr), 0);
    goto_cycle(g + 61);
    abort = 1'b0;
    @(negedge clk);
    chk("abort_ro_en", 32'(ro_en), 0);
    chk("abort_ro_sel", 32'(ro_sel), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 0);
    @(posedge clk); #1;
    run_one(1, 6'h07, 1'b0, d, lat);
    chk("after_abort_data", 32'(d), 32'h0FF);
    chk("after_abort_latency", 32'(lat), 119);

    bus.req_chal[5:0] = 6'h2C;
    bus.req_valid = 2'b01;
    wait_grant(2'b01, who, g);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    goto_cycle(g + 13);
    rst = 1'b1;
    goto_cycle(g + 14);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ro_en", 32'(ro_en), 0);
    chk("rst_ro_sel", 32'(ro_sel), 0);
    chk("rst_ro_clr", 32'(ro_clr), 1);
    chk("rst_ro_chal", 32'(ro_chal), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 0);
    @(posedge clk); #1;
    bus.req_chal  = {6'h01, 6'h02};
    bus.req_valid = 2'b11;
    wait_grant(2'b11, who, g);
    chk("rst_prio", 32'(who), 0);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    wait_rsp(r);
    handshake(1'b0);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1, "timeout");
  end

endmodule
